// File: rtl/modular_reducer_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | modular_reducer_if : operand/result stream and stall for reducer   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface modular_reducer_if #(
  parameter int W = 30
);
  logic           stall;
  logic           in_valid;
  logic [2*W-1:0] c;
  logic           out_valid;
  logic [W-1:0]   r;

  modport master (output stall, in_valid, c, input out_valid, r);
  modport slave  (input stall, in_valid, c, output out_valid, r);
endinterface
`default_nettype wire

// File: rtl/modular_reducer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | modular_reducer : 5-stage Barrett reduction of a 2W-bit product    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module modular_reducer #(
  parameter int          W = 30,
  parameter int unsigned Q = 998244353
) (
  input  logic             clk,
  input  logic             rst,
  modular_reducer_if.slave bus
);
  localparam logic [2*W:0] c_pow2    = {1'b1, {(2*W){1'b0}}};
  localparam logic [2*W:0] c_mu_full = c_pow2 / (2*W+1)'(Q);
  localparam logic [W:0]   MU        = c_mu_full[W:0];
  localparam logic [W+1:0] c_q       = (W+2)'(Q);

  logic             s1_valid_q, s1_valid_d;
  logic [W:0]       s1_q1_q,    s1_q1_d;
  logic [W+1:0]     s1_clo_q,   s1_clo_d;
  logic             s2_valid_q, s2_valid_d;
  logic [2*W+1:0]   s2_q2_q,    s2_q2_d;
  logic [W+1:0]     s2_clo_q,   s2_clo_d;
  logic             s3_valid_q, s3_valid_d;
  logic [W+1:0]     s3_p_q,     s3_p_d;
  logic [W+1:0]     s3_clo_q,   s3_clo_d;
  logic             s4_valid_q, s4_valid_d;
  logic [W+1:0]     s4_t_q,     s4_t_d;
  logic             out_valid_q, out_valid_d;
  logic [W-1:0]     r_q,         r_d;
  logic [W:0]       w_q3;
  logic [W+1:0]     w_t1;

  always_comb begin
    s1_valid_d  = bus.in_valid;
    s1_q1_d     = (W+1)'(bus.c >> (W-1));
    s1_clo_d    = bus.c[W+1:0];

    s2_valid_d  = s1_valid_q;
    s2_q2_d     = (2*W+2)'(s1_q1_q) * (2*W+2)'(MU);
    s2_clo_d    = s1_clo_q;

    // Only the low W+2 bits of q3*Q matter: the true remainder is below 3Q.
    w_q3        = (W+1)'(s2_q2_q >> (W+1));
    s3_valid_d  = s2_valid_q;
    s3_p_d      = (W+2)'(w_q3) * c_q;
    s3_clo_d    = s2_clo_q;

    s4_valid_d  = s3_valid_q;
    s4_t_d      = s3_clo_q - s3_p_q;

    w_t1        = (s4_t_q >= c_q) ? (s4_t_q - c_q) : s4_t_q;
    out_valid_d = s4_valid_q;
    r_d         = (w_t1 >= c_q) ? W'(w_t1 - c_q) : W'(w_t1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      s3_valid_q  <= 1'b0;
      s4_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      r_q         <= '0;
    end else if (!bus.stall) begin
      s1_valid_q  <= s1_valid_d;
      s1_q1_q     <= s1_q1_d;
      s1_clo_q    <= s1_clo_d;
      s2_valid_q  <= s2_valid_d;
      s2_q2_q     <= s2_q2_d;
      s2_clo_q    <= s2_clo_d;
      s3_valid_q  <= s3_valid_d;
      s3_p_q      <= s3_p_d;
      s3_clo_q    <= s3_clo_d;
      s4_valid_q  <= s4_valid_d;
      s4_t_q      <= s4_t_d;
      out_valid_q <= out_valid_d;
      r_q         <= r_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.r         = r_q;
endmodule
`default_nettype wire
